// File: rtl/vga_sync_receiver_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync receiver.
// The master is whatever drives the sync pins; the receiver is the slave.
interface vga_sync_receiver_if;
  localparam int unsigned XY_W  = 10;
  localparam int unsigned ERR_W = 8;

  logic             pix_ce;
  logic             vga_h_sync;
  logic             vga_v_sync;
  logic [XY_W-1:0]  rx_x;
  logic [XY_W-1:0]  rx_y;
  logic             rx_active;
  logic             locked;
  logic             frame_start;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output pix_ce, vga_h_sync, vga_v_sync,
    input  rx_x, rx_y, rx_active, locked, frame_start, err_cnt
  );

  modport slave (
    input  pix_ce, vga_h_sync, vga_v_sync,
    output rx_x, rx_y, rx_active, locked, frame_start, err_cnt
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from VGA sync edges, checks line/frame timing,
// and reports lock, a frame-start strobe and a saturating error count.
module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic                board_clk,
  input  logic                Reset,
  vga_sync_receiver_if.slave  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned XY_W    = 10;
  localparam int unsigned ERR_W   = 8;

  localparam logic [HW-1:0]    H_MAX      = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0]    H_MISS     = HW'(2 * H_TOTAL - 1);
  localparam logic [HW-1:0]    H_LINE_END = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_PW_END   = HW'(H_SYNC - 1);
  localparam logic [HW-1:0]    H_OFF      = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0]    H_END      = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0]    V_OFF      = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0]    V_END      = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0]    V_MAX      = '1;
  localparam logic [VW-1:0]    V_FRAME    = VW'(V_TOTAL);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic hs_meta, hs_sync, hs_hist;
  logic vs_meta, vs_sync, vs_hist;
  logic hs_edge_c, hs_rel_c, vs_edge_c;

  logic [HW-1:0] h_cnt;
  logic [HW-1:0] hs_width;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] line_cnt;

  logic line_fail_c, frame_ok_c;

  state_t state_q, state_d;
  logic   track_bad_q, track_bad_d;
  logic   err_inc_c, frame_start_d;

  logic             locked_q;
  logic             frame_start_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [XY_W-1:0]  rx_x_q, rx_y_q;
  logic             rx_active_q;
  logic             h_in_c, v_in_c, act_c;

  // Two-flop synchronizers, then a history flop advanced per pixel
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      hs_meta <= ~SYNC_POL;
      hs_sync <= ~SYNC_POL;
      hs_hist <= ~SYNC_POL;
      vs_meta <= ~SYNC_POL;
      vs_sync <= ~SYNC_POL;
      vs_hist <= ~SYNC_POL;
    end else begin
      hs_meta <= bus.vga_h_sync;
      hs_sync <= hs_meta;
      vs_meta <= bus.vga_v_sync;
      vs_sync <= vs_meta;
      if (bus.pix_ce) begin
        hs_hist <= hs_sync;
        vs_hist <= vs_sync;
      end
    end
  end

  assign hs_edge_c = bus.pix_ce && (hs_hist != SYNC_POL) && (hs_sync == SYNC_POL);
  assign hs_rel_c  = bus.pix_ce && (hs_hist == SYNC_POL) && (hs_sync != SYNC_POL);
  assign vs_edge_c = bus.pix_ce && (vs_hist != SYNC_POL) && (vs_sync == SYNC_POL);

  // Pixel, pulse-width, row and line counters
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      h_cnt    <= '0;
      hs_width <= '0;
      v_cnt    <= '0;
      line_cnt <= '0;
    end else if (bus.pix_ce) begin
      if (hs_edge_c)
        h_cnt <= '0;
      else if (h_cnt != H_MAX)
        h_cnt <= h_cnt + HW'(1);

      if (hs_rel_c)
        hs_width <= h_cnt;

      if (vs_edge_c)
        v_cnt <= '0;
      else if (hs_edge_c && (v_cnt != V_MAX))
        v_cnt <= v_cnt + VW'(1);

      if (vs_edge_c)
        line_cnt <= '0;
      else if (hs_edge_c && (line_cnt != V_MAX))
        line_cnt <= line_cnt + VW'(1);
    end
  end

  // A line fails on a mistimed hsync or when hsync never arrives
  assign line_fail_c = (hs_edge_c && ((h_cnt != H_LINE_END) || (hs_width != H_PW_END)))
                    || (bus.pix_ce && !hs_edge_c && (h_cnt == H_MISS));
  assign frame_ok_c  = (line_cnt + VW'(hs_edge_c)) == V_FRAME;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= SEARCH;
      track_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      track_bad_q <= track_bad_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    track_bad_d   = track_bad_q;
    err_inc_c     = 1'b0;
    frame_start_d = vs_edge_c && (state_q == LOCKED);
    unique case (state_q)
      SEARCH: begin
        if (vs_edge_c) begin
          state_d     = TRACK;
          track_bad_d = 1'b0;
        end
      end
      TRACK: begin
        // A frame only qualifies if every line since the last vsync was clean
        if (vs_edge_c) begin
          if (frame_ok_c && !track_bad_q && !line_fail_c)
            state_d = LOCKED;
          track_bad_d = 1'b0;
        end else if (line_fail_c) begin
          track_bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (line_fail_c || (vs_edge_c && !frame_ok_c)) begin
          state_d   = SEARCH;
          err_inc_c = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      locked_q      <= (state_d == LOCKED);
      frame_start_q <= frame_start_d;
      if (err_inc_c && (err_cnt_q != ERR_MAX))
        err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign h_in_c = (h_cnt >= H_OFF) && (h_cnt < H_END);
  assign v_in_c = (v_cnt >= V_OFF) && (v_cnt < V_END);
  assign act_c  = locked_q && h_in_c && v_in_c;

  // Coordinates follow the counters by one clock
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      rx_x_q      <= '0;
      rx_y_q      <= '0;
      rx_active_q <= 1'b0;
    end else begin
      rx_active_q <= act_c;
      rx_x_q      <= act_c ? XY_W'(h_cnt - H_OFF) : '0;
      rx_y_q      <= act_c ? XY_W'(v_cnt - V_OFF) : '0;
    end
  end

  assign bus.rx_x        = rx_x_q;
  assign bus.rx_y        = rx_y_q;
  assign bus.rx_active   = rx_active_q;
  assign bus.locked      = locked_q;
  assign bus.frame_start = frame_start_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: scaled-down timing, directed lock/error scenarios
// and randomly corrupted frames compared pixel by pixel with a reference model.
module tb_vga_sync_receiver;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit POL = 1'b0;

  localparam int K_CLEAN  = 0;
  localparam int K_LONG   = 1;
  localparam int K_SHORT  = 2;
  localparam int K_WIDE   = 3;
  localparam int K_NOSYNC = 4;

  localparam int PH_SEARCH = 0;
  localparam int PH_TRACK  = 1;
  localparam int PH_LOCKED = 2;

  logic board_clk;
  logic Reset;
  vga_sync_receiver_if bus();

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .board_clk(board_clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  int n_checks;
  int n_errors;

  // Reference model: pixels since the last hsync start, measured pulse length,
  // lines since the last vsync start, and the lock phase.
  bit m_hp, m_vp;
  bit drv_h, drv_v;
  int m_px, m_pulse, m_line, phase, m_err;
  bit m_bad;
  int exp_x, exp_y, exp_act, exp_locked, exp_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hp = 1'b0; m_vp = 1'b0;
    m_px = 1; m_pulse = 1; m_line = 0;
    phase = PH_SEARCH; m_bad = 1'b0; m_err = 0;
    exp_x = 0; exp_y = 0; exp_act = 0; exp_locked = 0; exp_fs = 0;
  endtask

  task automatic model_step(input bit hl, input bit vl);
    bit hs_start, hs_end, vs_start, line_bad, frame_good;
    int col, row;
    hs_start = hl && !m_hp;
    hs_end   = !hl && m_hp;
    vs_start = vl && !m_vp;
    line_bad = 1'b0;
    if (hs_start)
      line_bad = (m_px != HT) || (m_pulse != HS);
    else if (m_px == 2 * HT)
      line_bad = 1'b1;
    frame_good = (m_line + int'(hs_start)) == VT;
    exp_fs = (vs_start && phase == PH_LOCKED) ? 1 : 0;
    case (phase)
      PH_SEARCH: if (vs_start) begin phase = PH_TRACK; m_bad = 1'b0; end
      PH_TRACK: begin
        if (vs_start) begin
          if (frame_good && !m_bad && !line_bad) phase = PH_LOCKED;
          m_bad = 1'b0;
        end else if (line_bad) begin
          m_bad = 1'b1;
        end
      end
      default: begin
        if (line_bad || (vs_start && !frame_good)) begin
          phase = PH_SEARCH;
          if (m_err < 255) m_err++;
        end
      end
    endcase
    if (hs_end) m_pulse = m_px;
    if (hs_start) m_px = 1;
    else if (m_px <= 2 * HT) m_px++;
    if (vs_start) m_line = 0;
    else if (hs_start && m_line < 1023) m_line++;
    m_hp = hl;
    m_vp = vl;
    col = m_px - 1 - (HS + HB);
    row = m_line - (VS + VB);
    exp_locked = (phase == PH_LOCKED) ? 1 : 0;
    exp_act = (phase == PH_LOCKED && col >= 0 && col < HA && row >= 0 && row < VA) ? 1 : 0;
    exp_x = exp_act ? col : 0;
    exp_y = exp_act ? row : 0;
  endtask

  // One pixel period: the DUT sees the level driven on the previous pixel
  task automatic drive_pixel(input bit h_on, input bit v_on);
    @(posedge board_clk); #1;
    bus.pix_ce     = 1'b1;
    bus.vga_h_sync = h_on ? POL : ~POL;
    bus.vga_v_sync = v_on ? POL : ~POL;
    @(posedge board_clk);
    model_step(drv_h, drv_v);
    drv_h = h_on;
    drv_v = v_on;
    #1;
    bus.pix_ce = 1'b0;
    check("locked", 32'(bus.locked), exp_locked);
    check("frame_start", 32'(bus.frame_start), exp_fs);
    check("err_cnt", 32'(bus.err_cnt), m_err);
    @(posedge board_clk); #1;
    check("rx_x", 32'(bus.rx_x), exp_x);
    check("rx_y", 32'(bus.rx_y), exp_y);
    check("rx_active", 32'(bus.rx_active), exp_act);
    repeat ($urandom_range(0, 2)) @(posedge board_clk);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int kind);
    int len, pw;
    for (int l = 0; l < nlines; l++) begin
      len = HT;
      pw  = HS;
      if (l == bad_line) begin
        case (kind)
          K_LONG:   len = HT + 1;
          K_SHORT:  len = HT - 1;
          K_WIDE:   pw  = HS + 1;
          K_NOSYNC: begin len = 2 * HT + 3; pw = 0; end
          default: ;
        endcase
      end
      for (int p = 0; p < len; p++)
        drive_pixel(p < pw, l < VS);
    end
  endtask

  task automatic apply_reset();
    @(posedge board_clk); #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_rx_x", 32'(bus.rx_x), 0);
    check("rst_rx_y", 32'(bus.rx_y), 0);
    check("rst_rx_active", 32'(bus.rx_active), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_frame_start", 32'(bus.frame_start), 0);
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    repeat (2) @(posedge board_clk);
    #1;
    Reset = 1'b0;
    repeat (3) @(posedge board_clk);
  endtask

  initial begin
    int kind, bad, lines;
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    bus.pix_ce = 1'b0;
    bus.vga_h_sync = ~POL;
    bus.vga_v_sync = ~POL;
    drv_h = 1'b0;
    drv_v = 1'b0;
    model_reset();

    apply_reset();

    // Short frame in TRACK must not lock; the next full frame does
    send_frame(VT - 1, -1, K_CLEAN);
    send_frame(VT, -1, K_CLEAN);
    check("dir_short_no_lock", 32'(bus.locked), 0);
    send_frame(VT, -1, K_CLEAN);
    check("dir_lock_after_clean", 32'(bus.locked), 1);
    check("dir_err_after_lock", 32'(bus.err_cnt), 0);

    // Stretched line while locked
    send_frame(VT, 5, K_LONG);
    check("dir_long_unlock", 32'(bus.locked), 0);
    check("dir_long_err", 32'(bus.err_cnt), 1);
    send_frame(VT, -1, K_CLEAN);
    send_frame(VT, -1, K_CLEAN);
    check("dir_relock", 32'(bus.locked), 1);

    // Missing hsync while locked
    send_frame(VT, 4, K_NOSYNC);
    check("dir_nosync_unlock", 32'(bus.locked), 0);
    check("dir_nosync_err", 32'(bus.err_cnt), 2);
    send_frame(VT, -1, K_CLEAN);
    send_frame(VT, -1, K_CLEAN);
    check("dir_nosync_relock", 32'(bus.locked), 1);

    // Reset in the middle of a locked frame
    send_frame(5, -1, K_CLEAN);
    check("dir_pre_reset_locked", 32'(bus.locked), 1);
    apply_reset();
    send_frame(VT, -1, K_CLEAN);
    send_frame(VT, -1, K_CLEAN);
    check("dir_reset_relock", 32'(bus.locked), 1);
    check("dir_reset_err", 32'(bus.err_cnt), 0);

    // Random mix of clean and corrupted frames
    for (int f = 0; f < 30; f++) begin
      kind  = $urandom_range(0, 12);
      bad   = $urandom_range(0, VT - 1);
      lines = VT;
      if (kind <= 6) kind = K_CLEAN;
      else if (kind == 7) kind = K_LONG;
      else if (kind == 8) kind = K_SHORT;
      else if (kind == 9) kind = K_WIDE;
      else if (kind == 10) kind = K_NOSYNC;
      else if (kind == 11) begin kind = K_CLEAN; lines = VT - 1; end
      else begin kind = K_CLEAN; lines = VT + 1; end
      send_frame(lines, bad, kind);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
